bit_population_counter_pipe: RTL and testbench

// - Fully pipelined, parametrised population counter; next generation of the single-shot popcount block.
// - Accepts one word per cycle with no busy window; valid/ready backpressure from downstream.
// - Runtime mode counts ones or zeros.
// - Sits between a streaming data source and the statistics/compare logic in the datapath.

---
 rtl/bit_popcnt_pkg.sv | 36 +++
 rtl/bit_popcnt_chunk.sv | 18 +
 rtl/bit_population_counter_pipe.sv | 105 ++++++++++
 tb/tb_bit_population_counter_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_popcnt_pkg.sv
// Shared types and sizing helpers for the pipelined population counter.
package bit_popcnt_pkg;

    typedef enum logic {
        POPCNT_ONES  = 1'b0,
        POPCNT_ZEROS = 1'b1
    } popcnt_mode_t;

    // Leaf chunk count, rounded up to a power of two so the adder tree is balanced.
    function automatic int unsigned np_of(input int unsigned width, input int unsigned chunk_width);
        int unsigned nchunk;
        int unsigned np;
        nchunk = (width + chunk_width - 1) / chunk_width;
        np = 1;
        while (np < nchunk) np = np * 2;
        return np;
    endfunction

    function automatic int unsigned lat_of(input int unsigned width, input int unsigned chunk_width);
        return 1 + $clog2(np_of(width, chunk_width));
    endfunction

    function automatic int unsigned cnt_width(input int unsigned nbits);
        return $clog2(nbits) + 1;
    endfunction

    // Bit offset of a tree level inside the flattened tree vector.
    function automatic int unsigned tree_offset(input int unsigned level, input int unsigned np,
                                                input int unsigned leaf_w);
        int unsigned off;
        off = 0;
        for (int unsigned j = 0; j < level; j++) off = off + (np >> j) * (leaf_w + j);
        return off;
    endfunction

endpackage

// File: rtl/bit_popcnt_chunk.sv
// Combinational population count of one CHUNK_WIDTH-bit leaf chunk.
module bit_popcnt_chunk
    import bit_popcnt_pkg::*;
#(
    parameter int unsigned CHUNK_WIDTH = 4
) (
    input  logic [CHUNK_WIDTH-1:0]            data,
    output logic [cnt_width(CHUNK_WIDTH)-1:0] count
);

    localparam int unsigned CNT_W = cnt_width(CHUNK_WIDTH);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < CHUNK_WIDTH; i++) count = count + CNT_W'(data[i]);
    end

endmodule

// File: rtl/bit_population_counter_pipe.sv
// Fully pipelined popcount (ones or zeros) with one global valid/ready advance enable.
// Optional registered threshold compare enabled by macro BIT_POPCNT_THRESH_EN.
module bit_population_counter_pipe
    import bit_popcnt_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned CHUNK_WIDTH = 4
) (
    input  logic                        clk_i,
    input  logic                        arst_n_i,
    input  logic [WIDTH-1:0]            data_i,
    input  logic                        data_val_i,
    input  logic                        mode_i,
    output logic                        ready_o,
    output logic [cnt_width(WIDTH)-1:0] data_o,
    output logic                        data_val_o,
    input  logic                        ready_i
`ifdef BIT_POPCNT_THRESH_EN
    ,
    input  logic [cnt_width(WIDTH)-1:0] thresh_i,
    output logic                        ge_thresh_o
`endif
);

    localparam int unsigned NP     = np_of(WIDTH, CHUNK_WIDTH);
    localparam int unsigned LEVELS = $clog2(NP);
    localparam int unsigned LEAF_W = cnt_width(CHUNK_WIDTH);
    localparam int unsigned OUT_W  = cnt_width(WIDTH);
    localparam int unsigned SUM_W  = LEAF_W + LEVELS;
    localparam int unsigned TREE_W = tree_offset(LEVELS + 1, NP, LEAF_W);
    localparam int unsigned ROOT   = tree_offset(LEVELS, NP, LEAF_W);

    logic                    adv;
    logic [NP*CHUNK_WIDTH-1:0] padded;
    logic [TREE_W-1:0]       tree;
    logic [TREE_W-1:0]       tree_next;
    logic [LEVELS:0]         val;
    logic [LEVELS:0]         val_next;

    assign adv        = ready_i || !val[LEVELS];
    assign ready_o    = adv;
    assign data_val_o = val[LEVELS];
    assign data_o     = tree[ROOT +: OUT_W];

    // Inversion happens before padding so pad bits stay zero in both modes.
    always_comb begin
        padded = '0;
        padded[WIDTH-1:0] = (popcnt_mode_t'(mode_i) == POPCNT_ZEROS) ? ~data_i : data_i;
    end

    always_comb begin
        val_next    = val << 1;
        val_next[0] = data_val_i;
    end

    genvar i, l;
    for (i = 0; i < NP; i++) begin : g_leaf
        bit_popcnt_chunk #(.CHUNK_WIDTH(CHUNK_WIDTH)) u_chunk (
            .data  (padded[i*CHUNK_WIDTH +: CHUNK_WIDTH]),
            .count (tree_next[i*LEAF_W +: LEAF_W])
        );
    end

    // Every level lives in one flat vector; level l has NP>>l nodes of LEAF_W+l bits.
    for (l = 1; l <= LEVELS; l++) begin : g_level
        localparam int unsigned W   = LEAF_W + l;
        localparam int unsigned SRC = tree_offset(l - 1, NP, LEAF_W);
        localparam int unsigned DST = tree_offset(l, NP, LEAF_W);
        for (i = 0; i < (NP >> l); i++) begin : g_node
            assign tree_next[DST + i*W +: W] = {1'b0, tree[SRC + (2*i)*(W-1) +: W-1]}
                                             + {1'b0, tree[SRC + (2*i+1)*(W-1) +: W-1]};
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            val  <= '0;
            tree <= '0;
        end else if (adv) begin
            val  <= val_next;
            tree <= tree_next;
        end
    end

`ifdef BIT_POPCNT_THRESH_EN
    logic [SUM_W-1:0] thresh_ext;
    logic             ge;

    always_comb begin
        thresh_ext = '0;
        thresh_ext[OUT_W-1:0] = thresh_i;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ge <= 1'b0;
        end else if (adv) begin
            ge <= (tree_next[ROOT +: SUM_W] >= thresh_ext);
        end
    end

    assign ge_thresh_o = ge;
`endif

endmodule

// File: tb/tb_bit_population_counter_pipe.sv
// Self-checking bench: vector table, hand-written corner sequences, randomized stream vs queue model.
module tb_bit_population_counter_pipe;

    logic        clk;
    logic        arst_n;
    logic [31:0] data_i;
    logic        data_val_i;
    logic        mode_i;
    logic        ready_o;
    logic [5:0]  data_o;
    logic        data_val_o;
    logic        ready_i;
`ifdef BIT_POPCNT_THRESH_EN
    logic [5:0]  thresh_i;
    logic        ge_thresh_o;
    logic [4:0]  d10_thresh;
    logic        d10_ge;
`endif

    logic [9:0]  d10_data;
    logic        d10_val;
    logic        d10_mode;
    logic        d10_ready_o;
    logic [4:0]  d10_out;
    logic        d10_val_o;
    logic        d10_ready;

    bit_population_counter_pipe #(.WIDTH(32), .CHUNK_WIDTH(4)) u_dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .data_i      (data_i),
        .data_val_i  (data_val_i),
        .mode_i      (mode_i),
        .ready_o     (ready_o),
        .data_o      (data_o),
        .data_val_o  (data_val_o),
        .ready_i     (ready_i)
`ifdef BIT_POPCNT_THRESH_EN
        ,
        .thresh_i    (thresh_i),
        .ge_thresh_o (ge_thresh_o)
`endif
    );

    bit_population_counter_pipe #(.WIDTH(10), .CHUNK_WIDTH(4)) u_dut10 (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .data_i      (d10_data),
        .data_val_i  (d10_val),
        .mode_i      (d10_mode),
        .ready_o     (d10_ready_o),
        .data_o      (d10_out),
        .data_val_o  (d10_val_o),
        .ready_i     (d10_ready)
`ifdef BIT_POPCNT_THRESH_EN
        ,
        .thresh_i    (d10_thresh),
        .ge_thresh_o (d10_ge)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic        mode;
        int          count;
        logic        ge;
    } vec_t;

    typedef struct {
        int   count;
        logic ge;
    } exp_t;

    int   tests;
    int   fails;
    int   cur_thresh;
    exp_t q[$];
    logic hold_pending;
    int   held;
    vec_t vecs[12];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    function automatic int exp_count(input logic [31:0] d, input logic m);
        return m ? $countones(~d) : $countones(d);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after a negedge; returns there one cycle later.
    task automatic step(input logic v, input logic [31:0] d, input logic m, input logic r,
                        output logic acc);
        exp_t e;
        data_val_i = v;
        data_i     = d;
        mode_i     = m;
        ready_i    = r;
`ifdef BIT_POPCNT_THRESH_EN
        thresh_i   = 6'(cur_thresh);
`endif
        #1;
        if (hold_pending) begin
            check("stall_valid", int'(data_val_o), 1);
            check("stall_data", int'(data_o), held);
        end
        hold_pending = data_val_o && !ready_i;
        held = int'(data_o);
        if (data_val_o && ready_i) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_beat: got data_o %0d, expected no beat", data_o);
            end else begin
                e = q.pop_front();
                check("stream_count", int'(data_o), e.count);
`ifdef BIT_POPCNT_THRESH_EN
                check("stream_ge", int'(ge_thresh_o), int'(e.ge));
`endif
            end
        end
        acc = v && ready_o;
        if (acc) begin
            e.count = exp_count(d, m);
            e.ge    = (e.count >= cur_thresh);
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single beat into an empty pipeline; the accept edge counts as edge 1.
    task automatic run32(input vec_t v);
        int edges;
        data_val_i = 1'b1;
        data_i     = v.data;
        mode_i     = v.mode;
        ready_i    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_val_i = 1'b0;
        edges = 1;
        while (!data_val_o && edges < 12) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("latency", edges, 4);
        check("table_count", int'(data_o), v.count);
`ifdef BIT_POPCNT_THRESH_EN
        check("table_ge", int'(ge_thresh_o), int'(v.ge));
`endif
    endtask

    task automatic run10(input logic [9:0] d, input logic m, input int exp, input logic exp_ge);
        int edges;
        d10_val  = 1'b1;
        d10_data = d;
        d10_mode = m;
        @(posedge clk);
        @(negedge clk);
        d10_val = 1'b0;
        edges = 1;
        while (!d10_val_o && edges < 12) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("w10_latency", edges, 3);
        check("w10_count", int'(d10_out), exp);
`ifdef BIT_POPCNT_THRESH_EN
        check("w10_ge", int'(d10_ge), int'(exp_ge));
`else
        if (exp_ge === 1'bx) $display("note: unexpected x");
`endif
    endtask

    initial begin
        logic        acc;
        int          idx;
        int          waited;
        logic [31:0] beats[5];

        vecs[0]  = '{32'h0000_000E, 1'b0,  3, 1'b0};
        vecs[1]  = '{32'h0000_0000, 1'b0,  0, 1'b0};
        vecs[2]  = '{32'hFFFF_FFFF, 1'b0, 32, 1'b1};
        vecs[3]  = '{32'h0000_0001, 1'b0,  1, 1'b0};
        vecs[4]  = '{32'h0000_00FF, 1'b1, 24, 1'b1};
        vecs[5]  = '{32'h0000_0000, 1'b1, 32, 1'b1};
        vecs[6]  = '{32'hFFFF_FFFF, 1'b1,  0, 1'b0};
        vecs[7]  = '{32'h0000_FFFF, 1'b0, 16, 1'b1};
        vecs[8]  = '{32'h0000_7FFF, 1'b0, 15, 1'b0};
        vecs[9]  = '{32'h8000_0001, 1'b0,  2, 1'b0};
        vecs[10] = '{32'hA5A5_A5A5, 1'b0, 16, 1'b1};
        vecs[11] = '{32'h1234_5678, 1'b1, 19, 1'b1};

        tests = 0;
        fails = 0;
        hold_pending = 1'b0;
        held = 0;
        cur_thresh = 16;
        arst_n = 1'b0;
        data_i = '0;
        data_val_i = 1'b0;
        mode_i = 1'b0;
        ready_i = 1'b1;
        d10_data = '0;
        d10_val = 1'b0;
        d10_mode = 1'b0;
        d10_ready = 1'b1;
`ifdef BIT_POPCNT_THRESH_EN
        thresh_i = 6'd16;
        d10_thresh = 5'd5;
`endif

        #3;
        check("rst_valid", int'(data_val_o), 0);
        check("rst_data", int'(data_o), 0);
        check("rst_ready", int'(ready_o), 1);
        check("rst_valid_w10", int'(d10_val_o), 0);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        for (int unsigned k = 0; k < 12; k++) run32(vecs[k]);

        run10(10'h3FF, 1'b1, 0, 1'b0);
        run10(10'h000, 1'b1, 10, 1'b1);
        run10(10'h3FF, 1'b0, 10, 1'b1);
        run10(10'h155, 1'b0, 5, 1'b1);

        // Back-to-back: results must emerge on consecutive cycles.
        data_val_i = 1'b1;
        mode_i = 1'b0;
        data_i = 32'h0000_0000;
        @(posedge clk); @(negedge clk);
        data_i = 32'hFFFF_FFFF;
        @(posedge clk); @(negedge clk);
        data_i = 32'h0000_0001;
        @(posedge clk); @(negedge clk);
        data_val_i = 1'b0;
        waited = 0;
        while (!data_val_o && waited < 10) begin
            @(posedge clk); @(negedge clk);
            waited++;
        end
        check("b2b_valid0", int'(data_val_o), 1);
        check("b2b_data0", int'(data_o), 0);
        @(posedge clk); @(negedge clk);
        check("b2b_valid1", int'(data_val_o), 1);
        check("b2b_data1", int'(data_o), 32);
        @(posedge clk); @(negedge clk);
        check("b2b_valid2", int'(data_val_o), 1);
        check("b2b_data2", int'(data_o), 1);
        @(posedge clk); @(negedge clk);
        check("b2b_after", int'(data_val_o), 0);

        // Fill with ready_i low until the pipeline backs up, then release.
        beats[0] = 32'h0000_0003;
        beats[1] = 32'h0000_00F0;
        beats[2] = 32'hFFFF_0000;
        beats[3] = 32'h0000_0001;
        beats[4] = 32'h7FFF_FFFF;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            step(1'b1, beats[idx], 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        check("stall_ready_o", int'(ready_o), 0);
        check("stall_accepted", idx, 4);
        for (int c = 0; c < 20; c++) begin
            step(idx < 5, beats[idx < 5 ? idx : 0], 1'b0, 1'b1, acc);
            if (acc) idx++;
        end
        check("stall_all_in", idx, 5);
        check("stall_drained", q.size(), 0);

        cur_thresh = 20;
        for (int c = 0; c < 400; c++) begin
            logic [31:0] d;
            case ($urandom_range(0, 7))
                0:       d = 32'h0;
                1:       d = 32'hFFFF_FFFF;
                default: d = $urandom;
            endcase
            step($urandom_range(0, 9) < 7, d, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 7, acc);
        end
        for (int c = 0; c < 20; c++) step(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, acc);
        check("rand_drained", q.size(), 0);

        // Three beats in flight, asynchronous reset pulse between clock edges.
        for (int c = 0; c < 3; c++) step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, acc);
        data_val_i = 1'b0;
        #2;
        arst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(data_val_o), 0);
        check("async_rst_data", int'(data_o), 0);
`ifdef BIT_POPCNT_THRESH_EN
        check("async_rst_ge", int'(ge_thresh_o), 0);
`endif
        q.delete();
        hold_pending = 1'b0;
        #1;
        arst_n = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 10; c++) step(1'b0, 32'h0, 1'b0, 1'b1, acc);
        check("post_rst_idle", int'(data_val_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
